rst_seq: RTL and testbench

Reset sequencer for the SoC clock domain. It sits between the PLL and `soc_cm0`, and generates the SoC's active-low reset `soc_rst_n`. The SoC leaves reset only after the PLL lock indication has been stable for a programmable time and a further hold period has elapsed. It re-enters reset on lock loss and, when configured, on a Cortex-M0 `SYSRESETREQ`.

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/rst_seq_sync.sv | 24 ++
 rtl/rst_seq.sv | 125 ++++++++++++
 tb/tb_rst_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABLE    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

    localparam int unsigned CNT_W    = 16;
    localparam logic [7:0]  LOST_SAT = 8'd255;

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == LOST_SAT) begin
            res = val;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module rst_seq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// SoC reset sequencer: qualifies PLL lock, holds reset, then releases soc_rst_n.
// Optional CPU SYSRESETREQ re-entry into HOLD is enabled by RST_SEQ_SYSRESETREQ_EN.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_STABLE = 16,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       sysresetreq,
    output logic       soc_rst_n,
    output logic [1:0] seq_state,
    output logic [7:0] lock_lost_cnt
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    logic             lock_s;
    logic             req_s;
    logic             inc_s;
    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       lost_q;
    logic [7:0]       lost_d;
    logic             soc_rst_n_q;

    rst_seq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk_i(sysclk),
        .rst_i(rst),
        .d_i  (pll_lock),
        .q_o  (lock_s)
    );

`ifdef RST_SEQ_SYSRESETREQ_EN
    assign req_s = sysresetreq;
`else
    logic unused_sysresetreq_s;
    assign unused_sysresetreq_s = sysresetreq;
    assign req_s = 1'b0;
`endif

    // Next-state, shared-counter and lock-loss counter logic.
    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        inc_s   = 1'b0;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_HOLD;
                end else begin
                    inc_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    inc_s = 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss takes priority over a simultaneous reset request.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    lost_d  = sat_inc8(lost_q);
                end else if (req_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (inc_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sequencer state and registered reset output.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            lost_q      <= 8'd0;
            soc_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            soc_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign soc_rst_n     = soc_rst_n_q;
    assign seq_state     = state_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed self-checking bench for rst_seq (LOCK_STABLE=4, HOLD_CYCLES=8, SYNC_STAGES=2).
module tb_rst_seq;

    logic       sysclk;
    logic       rst;
    logic       pll_lock;
    logic       sysresetreq;
    logic       soc_rst_n;
    logic [1:0] seq_state;
    logic [7:0] lock_lost_cnt;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int exp_lost   = 0;

    rst_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE(4),
        .HOLD_CYCLES(8)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .sysresetreq  (sysresetreq),
        .soc_rst_n    (soc_rst_n),
        .seq_state    (seq_state),
        .lock_lost_cnt(lock_lost_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input int act, input int exp);
        checks_cnt++;
        if (act != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input int st, input int rn);
        chk({tag, ".state"}, 32'(seq_state), st);
        chk({tag, ".rst_n"}, 32'(soc_rst_n), rn);
    endtask

    initial begin
        rst         = 1'b1;
        pll_lock    = 1'b1;
        sysresetreq = 1'b0;

        // Power-on: lock already high when rst is released.
        step(3);
        chk_out("reset", 0, 0);
        chk("reset.lost", 32'(lock_lost_cnt), 0);
        rst = 1'b0;
        step(2);  chk_out("t1.e2", 0, 0);
        step(1);  chk_out("t1.e3", 1, 0);
        step(3);  chk_out("t1.e6", 1, 0);
        step(1);  chk_out("t1.e7", 2, 0);
        step(7);  chk_out("t1.e14", 2, 0);
        step(1);  chk_out("t1.e15", 3, 1);
        chk("t1.lost", 32'(lock_lost_cnt), 0);

        // Lock glitch for 2 cycles while STABLE restarts qualification.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);  chk_out("t2.e3", 1, 0);
        pll_lock = 1'b0;
        step(2);  chk_out("t2.e5", 1, 0);
        pll_lock = 1'b1;
        step(1);  chk_out("t2.e6", 0, 0);
        step(1);  chk_out("t2.e7", 0, 0);
        step(1);  chk_out("t2.e8", 1, 0);
        step(3);  chk_out("t2.e11", 1, 0);
        step(1);  chk_out("t2.e12", 2, 0);
        step(7);  chk_out("t2.e19", 2, 0);
        step(1);  chk_out("t2.e20", 3, 1);
        chk("t2.lost", 32'(lock_lost_cnt), 0);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        step(1);  chk_out("t3.j", 3, 1);
        step(1);  chk_out("t3.j1", 3, 1);
        step(1);  chk_out("t3.j2", 0, 0);
        exp_lost = 1;
        chk("t3.lost", 32'(lock_lost_cnt), exp_lost);
        pll_lock = 1'b1;
        step(2);  chk_out("t3.m", 0, 0);
        step(12); chk_out("t3.m12", 2, 0);
        step(1);  chk_out("t3.m13", 3, 1);

`ifdef RST_SEQ_SYSRESETREQ_EN
        // Reset request in RUN re-enters HOLD for HOLD_CYCLES.
        sysresetreq = 1'b1;
        step(1);  chk_out("t5.k", 2, 0);
        sysresetreq = 1'b0;
        step(7);  chk_out("t5.k7", 2, 0);
        step(1);  chk_out("t5.k8", 3, 1);
        // Lock loss and reset request on the same edge: lock loss wins.
        pll_lock = 1'b0;
        step(2);  chk_out("t5b.j1", 3, 1);
        sysresetreq = 1'b1;
        step(1);  chk_out("t5b.j2", 0, 0);
        exp_lost = 2;
        chk("t5b.lost", 32'(lock_lost_cnt), exp_lost);
        sysresetreq = 1'b0;
        pll_lock = 1'b1;
        step(15); chk_out("t5b.run", 3, 1);
`else
        // Without the feature, a reset request never leaves RUN.
        sysresetreq = 1'b1;
        step(3);  chk_out("t5.ignored", 3, 1);
        sysresetreq = 1'b0;
        step(1);  chk_out("t5.after", 3, 1);
`endif

        // Repeated lock losses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            step(3);
            exp_lost = (exp_lost >= 255) ? 255 : exp_lost + 1;
            chk("t4.lost", 32'(lock_lost_cnt), exp_lost);
            pll_lock = 1'b1;
            step(15);
            chk("t4.rst_n", 32'(soc_rst_n), 1);
        end
        chk("t4.sat", 32'(lock_lost_cnt), 255);

        // rst pulse during HOLD.
        pll_lock = 1'b0;
        step(3);  chk_out("t6.wait", 0, 0);
        pll_lock = 1'b1;
        step(7);  chk_out("t6.hold", 2, 0);
        step(2);  chk_out("t6.hold2", 2, 0);
        rst = 1'b1;
        step(1);  chk_out("t6.rst", 0, 0);
        chk("t6.lost", 32'(lock_lost_cnt), 0);
        rst = 1'b0;
        step(2);  chk_out("t6.e2", 0, 0);
        step(1);  chk_out("t6.e3", 1, 0);
        step(4);  chk_out("t6.e7", 2, 0);
        step(7);  chk_out("t6.e14", 2, 0);
        step(1);  chk_out("t6.e15", 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
